// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTRY1 = 3'd0,
        ENTRY2 = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } seq_state_t;

    localparam logic [3:0]  DEF_ADDR_OP1 = 4'd0;
    localparam logic [3:0]  DEF_ADDR_OP2 = 4'd1;
    localparam logic [3:0]  DEF_ADDR_RES = 4'd2;

    // Largest operand magnitude that still fits a 16-bit signed value.
    localparam logic [14:0] MAX_MAG = 15'd32767;

    // Sign/magnitude to two's complement.
    function automatic logic [15:0] to_signed16(input logic neg, input logic [14:0] mag);
        return neg ? (16'd0 - {1'b0, mag}) : {1'b0, mag};
    endfunction

endpackage

// File: rtl/operand_accum.sv
// One keypad operand: decimal digit append with magnitude saturation check,
// sign toggle, and the resulting two's complement value.
module operand_accum
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        zero,
    input  logic        key_en,
    input  logic [3:0]  digit,
    input  logic        neg_en,
    output logic        update,
    output logic [15:0] next_value,
    output logic [15:0] value
);

    logic [14:0] mag;
    logic [14:0] mag_next;
    logic        sign;
    logic        sign_next;
    logic [18:0] appended;
    logic        key_ok;

    // Decide whether this cycle changes the operand and what it becomes.
    always_comb begin
        appended  = ({4'd0, mag} * 19'd10) + {15'd0, digit};
        key_ok    = key_en && (digit <= 4'd9) && (appended <= {4'd0, MAX_MAG});
        mag_next  = mag;
        sign_next = sign;
        if (neg_en) begin
            sign_next = ~sign;
        end else if (key_ok) begin
            mag_next = appended[14:0];
        end
        update     = neg_en || key_ok;
        next_value = to_signed16(sign_next, mag_next);
        value      = to_signed16(sign, mag);
    end

    // Operand register; cleared by reset, user clear or a committed result.
    always_ff @(posedge clk) begin
        if (reset || clear || zero) begin
            mag  <= '0;
            sign <= 1'b0;
        end else begin
            mag  <= mag_next;
            sign <= sign_next;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM that gathers two signed operands from keypad events, runs one
// add/subtract through the external ALU, checks overflow/timeout and commits
// the result to memory and the display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [3:0] ADDR_OP1       = DEF_ADDR_OP1,
    parameter logic [3:0] ADDR_OP2       = DEF_ADDR_OP2,
    parameter logic [3:0] ADDR_RES       = DEF_ADDR_RES
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        neg_valid,
    input  logic        op_valid,
    input  logic        op_sub,
    input  logic        eq_valid,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic        alu_sub,
    output logic        alu_start,
    input  logic [15:0] alu_out,
    input  logic        alu_finish,
    output logic        mem_we,
    output logic [3:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] display,
    output logic        complete,
    output logic        error,
    output logic        busy
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CNT_W-1:0] wait_cnt;

    logic        in_entry1;
    logic        in_entry2;
    logic        ctrl_hit;
    logic        upd1;
    logic        upd2;
    logic [15:0] next1;
    logic [15:0] next2;
    logic        overflow;
    logic        timeout_hit;

    assign in_entry1   = (state == ENTRY1);
    assign in_entry2   = (state == ENTRY2);
    // eq/op outrank neg, which outranks a digit; dropped strobes are lost.
    assign ctrl_hit    = eq_valid || op_valid;
    assign timeout_hit = (wait_cnt == CNT_LAST);

    // Signed overflow of the 16-bit result given the operands and operator.
    assign overflow = alu_sub ?
        ((alu_in1[15] != alu_in2[15]) && (alu_out[15] != alu_in1[15])) :
        ((alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15]));

    operand_accum u_op1 (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .zero       (state == DONE),
        .key_en     (in_entry1 && key_valid && !ctrl_hit && !neg_valid),
        .digit      (key_digit),
        .neg_en     (in_entry1 && neg_valid && !ctrl_hit),
        .update     (upd1),
        .next_value (next1),
        .value      (alu_in1)
    );

    operand_accum u_op2 (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .zero       (state == DONE),
        .key_en     (in_entry2 && key_valid && !ctrl_hit && !neg_valid),
        .digit      (key_digit),
        .neg_en     (in_entry2 && neg_valid && !ctrl_hit),
        .update     (upd2),
        .next_value (next2),
        .value      (alu_in2)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ENTRY1;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded strobes; clear overrides everything.
    always_comb begin
        state_next = state;
        alu_start  = 1'b0;
        busy       = 1'b0;
        complete   = 1'b0;
        error      = 1'b0;
        case (state)
            ENTRY1: if (op_valid) state_next = ENTRY2;
            ENTRY2: if (eq_valid) state_next = START;
            START: begin
                alu_start  = 1'b1;
                busy       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // A finish on the last allowed cycle still wins over timeout.
                if (alu_finish) begin
                    state_next = overflow ? ERR : WRITE;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end
            WRITE: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                complete   = 1'b1;
                state_next = ENTRY1;
            end
            ERR:     error = 1'b1;
            default: state_next = ENTRY1;
        endcase
        if (clear) state_next = ENTRY1;
    end

    // Datapath registers: wait counter, operator, display and memory port.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wait_cnt  <= '0;
            alu_sub   <= 1'b0;
            display   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;

            if (state != WAIT) begin
                wait_cnt <= '0;
            end else if (!alu_finish) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if ((in_entry1 && op_valid) || (in_entry2 && op_valid && !eq_valid)) begin
                alu_sub <= op_sub;
            end

            if (upd1) begin
                mem_we    <= 1'b1;
                mem_addr  <= ADDR_OP1;
                mem_wdata <= next1;
            end else if (upd2) begin
                mem_we    <= 1'b1;
                mem_addr  <= ADDR_OP2;
                mem_wdata <= next2;
            end

            if (state == WAIT) begin
                if (alu_finish) begin
                    if (!overflow) begin
                        display   <= alu_out;
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_RES;
                        mem_wdata <= alu_out;
                    end else begin
                        display <= '0;
                    end
                end else if (timeout_hit) begin
                    display <= '0;
                end
            end
        end
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Control FSM that sequences one signed add/subtract through the shared 16-bit ALU and operand memory. It turns keypad digit, sign, operator and equal events into signed operands, writes each updated operand to memory, and pulses the ALU start. It then waits for the ALU to finish, checks for signed overflow and timeout, writes the result back and drives the display and complete outputs. It sits between keypad decode and the addition/memory instances in the calculator top.

Parameters:
TIMEOUT_CYCLES, 64, maximum WAIT cycles without alu_finish before error
ADDR_OP1, 4'd0, memory address for operand 1
ADDR_OP2, 4'd1, memory address for operand 2
ADDR_RES, 4'd2, memory address for the result

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clear  in  1  user clear; returns the block to entry from any state
key_valid  in  1  one-cycle digit strobe
key_digit  in  4  digit 0-9; values above 9 are ignored
neg_valid  in  1  one-cycle strobe; toggles the sign of the current operand
op_valid  in  1  one-cycle operator strobe
op_sub  in  1  operator select: 0 add, 1 subtract (sampled with op_valid)
eq_valid  in  1  one-cycle equal strobe
alu_in1  out  16  operand 1, two's complement
alu_in2  out  16  operand 2, two's complement
alu_sub  out  1  ALU subtract select
alu_start  out  1  one-cycle ALU start pulse
alu_out  in  16  ALU result
alu_finish  in  1  ALU done strobe
mem_we  out  1  memory write enable, one-cycle pulse
mem_addr  out  4  memory address
mem_wdata  out  16  memory write data
display  out  16  result register
complete  out  1  one-cycle pulse when a result is committed
error  out  1  sticky error flag; cleared only by clear or reset
busy  out  1  high in START, WAIT and WRITE

Behaviour:
- Reset: the block is synchronous, active-high. State goes to ENTRY1. All outputs and accumulators are 0.
- All outputs are registered or decoded from the registered state. Priority order: reset > clear > everything else.
- States: ENTRY1, ENTRY2, START, WAIT, WRITE, DONE, ERR.
- Operand value = sign ? -mag : mag, where mag is 15-bit.
- Entry states (ENTRY1 uses operand 1, ENTRY2 uses operand 2). Per-cycle priority: eq/op > neg > key. Lower-priority strobes in the same cycle are dropped.
  - key accepted only if digit <= 9 and mag*10 + digit <= 32767. Otherwise it is ignored and no memory write occurs.
  - An accepted key or neg in cycle N gives mem_we=1 in N+1, with the operand's address and its updated signed value.
- ENTRY1:
  - op_valid: latch op_sub into alu_sub, go to ENTRY2.
  - eq_valid: ignored.
- ENTRY2:
  - eq_valid: go to START. An operand 2 with no digits entered is 0.
  - op_valid: re-latch op_sub and stay in ENTRY2.
- START (one cycle): alu_start=1. alu_in1 and alu_in2 are driven from the accumulators and held stable until the state returns to ENTRY1. Go to WAIT.
- WAIT:
  - Timeout counter is 0 on entry and increments each cycle without alu_finish.
  - alu_finish in cycle F: capture alu_out.
    - If there is no signed overflow, display <= alu_out and go to WRITE.
    - If there is overflow, go to ERR.
  - Overflow definition: for add, in1 and in2 have the same sign and the result sign differs. For sub, in1 and in2 have different signs and the result sign differs from in1.
  - Counter == TIMEOUT_CYCLES-1 with no finish: go to ERR. If finish arrives in that same cycle, finish wins.
  - alu_finish in any other state is ignored.
- WRITE (F+1): mem_we=1, addr ADDR_RES, data = result. Go to DONE.
- DONE (F+2): complete=1. Clear both accumulators, signs and alu_start. Go to ENTRY1. display holds its value.
- ERR: error=1 and display=0. No result write. All inputs except clear and reset are ignored.
- clear in any state: the next cycle is ENTRY1, with accumulators, error, display, mem_we and alu_start all at 0.
- Latency: eq accepted at N gives alu_start at N+1. Finish at F gives mem_we at F+1 and complete at F+2.

Decomposition:
- calc_pkg holds:
  - seq_state_t enum
  - ADDR_* defaults
  - MAX_MAG = 32767
- Sub-module operand_accum (instantiated twice) handles digit append, saturation check, sign toggle and the signed output.

Test Plan:
- Keys 1,2,3, op add, keys 4,5, eq; ALU model finishes 3 cycles after start with 168.
  - Memory writes: addr0 = 1, 12, 123; addr1 = 4, 45; addr2 = 168.
  - alu_in1=123, alu_in2=45, alu_sub=0, single-cycle alu_start.
  - display=168; complete pulses exactly 2 cycles after finish.
- neg, 5, op sub, 7, eq; ALU returns 0xFFF4 -> alu_in1=0xFFFB, alu_in2=7, alu_sub=1, display=0xFFF4, error=0.
- 30000 + 30000; ALU returns 0xEA60 -> error=1, display=0, no addr2 write. clear -> error=0, state ENTRY1.
- Digits 3,2,7,6,8 -> the fifth digit is rejected, operand stays 3276, exactly 4 addr0 writes. Digit 12 -> ignored.
- ALU never finishes -> error rises exactly TIMEOUT_CYCLES cycles after WAIT entry. Repeat with finish on the final cycle -> normal result, no error.
- key and op in the same cycle -> digit dropped and state ENTRY2. reset asserted during WAIT -> all outputs 0 next cycle, and a later alu_finish is ignored.
